// File: rtl/rx_descramble_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rx_descramble_ctrl_pkg
// Purpose : shared types and constants for the RX descrambler control slice.
//           Holds the block-type FSM encoding, the 2-bit sync header codes,
//           the ordered-set identifiers, the PIPE width codes, and small
//           decode helpers for symbols-per-cycle, LFSR select and lane masks.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package rx_descramble_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA_BLK  = 3'd1,
    OS_BLK    = 3'd2,
    SKP_BLK   = 3'd3,
    EIEOS_BLK = 3'd4
  } blk_state_e;

  localparam logic [1:0] HDR_DATA  = 2'b10;
  localparam logic [1:0] HDR_OS    = 2'b01;
  localparam logic [7:0] SKP_OS_ID = 8'hAA;
  localparam logic [7:0] EIEOS_ID  = 8'h00;

  localparam logic [5:0] PW_8  = 6'd8;
  localparam logic [5:0] PW_16 = 6'd16;
  localparam logic [5:0] PW_32 = 6'd32;

  // Symbols per cycle after reset (32-bit PIPE).
  localparam logic [2:0] NSYM_RESET = 3'd4;

  // Symbols per cycle for a PIPE width; unknown widths behave as 32-bit.
  function automatic logic [2:0] width_to_nsym(input logic [5:0] pw);
    logic [2:0] n;
    case (pw)
      PW_8:    n = 3'd1;
      PW_16:   n = 3'd2;
      PW_32:   n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // LFSR width select: 0/1/2 for 1/2/4 symbols per cycle.
  function automatic logic [1:0] nsym_to_sel(input logic [2:0] n);
    logic [1:0] sel;
    case (n)
      3'd1:    sel = 2'd0;
      3'd2:    sel = 2'd1;
      default: sel = 2'd2;
    endcase
    return sel;
  endfunction

  // Lanes carrying symbols this cycle, lane 0 first.
  function automatic logic [3:0] lane_mask(input logic [2:0] n);
    logic [3:0] m;
    case (n)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rx_descramble_ctrl_block_counter.sv
// ---------------------------------------------------------------------------
// rx_block_counter
// Purpose : tracks the symbol position (0..15) inside a 16-symbol block.
//           Counts only words that belong to a block; restarts on a block
//           start; flags a block start that arrives mid-block and reports
//           when the current word carries the last symbol of the block.
// Ports   : clk, reset      - clock, synchronous active-high reset
//           clr             - force count to 0 (training override)
//           valid           - word carries symbols this cycle
//           block_start     - qualified first word of a block
//           in_block        - this word belongs to a classified block
//           n_sym           - symbols per word in effect (1/2/4)
//           count           - registered symbol position of the next word
//           misalign        - block start seen while count != 0
//           wrap            - this word ends the current block
// ---------------------------------------------------------------------------
module rx_block_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       valid,
  input  logic       block_start,
  input  logic       in_block,
  input  logic [2:0] n_sym,
  output logic [3:0] count,
  output logic       misalign,
  output logic       wrap
);

  logic [3:0] count_q;
  logic [3:0] count_d;
  logic [3:0] base_s;
  logic [4:0] sum_s;

  // Position arithmetic for the word presented this cycle.
  always_comb begin
    base_s   = block_start ? 4'd0 : count_q;
    sum_s    = {1'b0, base_s} + {2'b00, n_sym};
    // Words are always aligned to N, so the sum lands exactly on 16 at the end.
    wrap     = sum_s[4];
    misalign = block_start & (count_q != 4'd0);
  end

  // Next count: hold on idle cycles, drop to 0 outside a block.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'd0;
    end else if (!valid) begin
      count_d = count_q;
    end else if (!in_block) begin
      count_d = 4'd0;
    end else begin
      count_d = sum_s[3:0];
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rx_descramble_ctrl.sv
// ---------------------------------------------------------------------------
// rx_descramble_ctrl
// Purpose : classifies received 128b/130b blocks from the sync header and
//           first symbol, and produces per-symbol LFSR advance / descramble
//           bypass controls, an LFSR reseed request at the end of an EIEOS
//           and a sync error pulse. All outputs are registered, one cycle
//           behind the inputs, with rxData delayed to stay aligned.
// Ports   : clk, reset      - clock, synchronous active-high reset
//           turnOff         - scrambling disabled (training); forces idle
//           PIPEWIDTH       - 8/16/32, anything else treated as 32
//           dataValid       - rxData carries symbols
//           blockStart      - first word of a block, qualifies syncHeader
//           syncHeader      - 10 data block, 01 ordered-set block
//           rxData          - symbols, symbol 0 in [7:0]
//           patternReset    - LFSR reseed request
//           LFSRSel         - LFSR width select 0/1/2
//           advance         - per-lane LFSR advance enable
//           bypass          - per-lane descramble bypass (1 = raw)
//           dataOut         - rxData delayed one cycle
//           dataValidOut    - dataValid delayed one cycle
//           syncErr         - illegal header or misaligned block start
// ---------------------------------------------------------------------------
module rx_descramble_ctrl
  import rx_descramble_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        turnOff,
  input  logic [5:0]  PIPEWIDTH,
  input  logic        dataValid,
  input  logic        blockStart,
  input  logic [1:0]  syncHeader,
  input  logic [31:0] rxData,
  output logic        patternReset,
  output logic [1:0]  LFSRSel,
  output logic [3:0]  advance,
  output logic [3:0]  bypass,
  output logic [31:0] dataOut,
  output logic        dataValidOut,
  output logic        syncErr
);

  blk_state_e  state_q;
  blk_state_e  state_d;
  blk_state_e  word_state_s;
  logic [2:0]  n_q;
  logic [2:0]  n_d;
  logic [2:0]  n_eff_s;
  logic [3:0]  mask_s;
  logic        new_block_s;
  logic        hdr_legal_s;
  logic        in_block_s;
  logic [3:0]  count_s;
  logic        misalign_s;
  logic        wrap_s;

  logic        pattern_reset_q, pattern_reset_d;
  logic [1:0]  lfsr_sel_q, lfsr_sel_d;
  logic [3:0]  advance_q, advance_d;
  logic [3:0]  bypass_q, bypass_d;
  logic [31:0] data_out_q, data_out_d;
  logic        data_valid_out_q, data_valid_out_d;
  logic        sync_err_q, sync_err_d;

  // Classify the word on the inputs: which block (if any) it belongs to.
  always_comb begin
    new_block_s  = dataValid & blockStart & ~turnOff;
    // A width change only lands on a block start; mid-block the latched N holds.
    n_eff_s      = new_block_s ? width_to_nsym(PIPEWIDTH) : n_q;
    mask_s       = lane_mask(n_eff_s);
    hdr_legal_s  = (syncHeader == HDR_DATA) | (syncHeader == HDR_OS);
    word_state_s = IDLE;
    if (new_block_s) begin
      case (syncHeader)
        HDR_DATA: word_state_s = DATA_BLK;
        HDR_OS: begin
          if (rxData[7:0] == SKP_OS_ID) begin
            word_state_s = SKP_BLK;
          end else if (rxData[7:0] == EIEOS_ID) begin
            word_state_s = EIEOS_BLK;
          end else begin
            word_state_s = OS_BLK;
          end
        end
        default: word_state_s = IDLE;
      endcase
    end else if (dataValid && (state_q != IDLE) && (count_s != 4'd0)) begin
      // Continuation of the current block. count 0 with a block state means
      // the previous block just ended and no new one started: fall to idle.
      word_state_s = state_q;
    end else begin
      word_state_s = IDLE;
    end
    in_block_s = (word_state_s != IDLE);
  end

  rx_block_counter u_block_counter (
    .clk         (clk),
    .reset       (reset),
    .clr         (turnOff),
    .valid       (dataValid),
    .block_start (new_block_s),
    .in_block    (in_block_s),
    .n_sym       (n_eff_s),
    .count       (count_s),
    .misalign    (misalign_s),
    .wrap        (wrap_s)
  );

  // State and latched-width registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= NSYM_RESET;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  // Next state: training override, hold on invalid cycles, else follow the word.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    if (turnOff) begin
      state_d = IDLE;
    end else if (dataValid) begin
      state_d = word_state_s;
      n_d     = n_eff_s;
    end else begin
      state_d = state_q;
    end
  end

  // Output decode for the word on the inputs, registered below.
  always_comb begin
    advance_d        = 4'h0;
    bypass_d         = 4'hF;
    pattern_reset_d  = 1'b0;
    sync_err_d       = 1'b0;
    lfsr_sel_d       = nsym_to_sel(n_eff_s);
    data_out_d       = rxData;
    data_valid_out_d = dataValid;
    if (turnOff) begin
      pattern_reset_d = 1'b1;
    end else if (dataValid) begin
      sync_err_d = new_block_s & (~hdr_legal_s | misalign_s);
      case (word_state_s)
        DATA_BLK: begin
          advance_d = mask_s;
          bypass_d  = ~mask_s;
        end
        OS_BLK: begin
          advance_d = mask_s;
          bypass_d  = 4'hF;
        end
        SKP_BLK: begin
          advance_d = 4'h0;
          bypass_d  = 4'hF;
        end
        EIEOS_BLK: begin
          advance_d       = 4'h0;
          bypass_d        = 4'hF;
          // Reseed with the word that carries symbol 15.
          pattern_reset_d = wrap_s;
        end
        default: begin
          advance_d = 4'h0;
          bypass_d  = 4'hF;
        end
      endcase
    end else begin
      advance_d = 4'h0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_reset_q  <= 1'b1;
      lfsr_sel_q       <= 2'd2;
      advance_q        <= 4'h0;
      bypass_q         <= 4'hF;
      data_out_q       <= 32'h0;
      data_valid_out_q <= 1'b0;
      sync_err_q       <= 1'b0;
    end else begin
      pattern_reset_q  <= pattern_reset_d;
      lfsr_sel_q       <= lfsr_sel_d;
      advance_q        <= advance_d;
      bypass_q         <= bypass_d;
      data_out_q       <= data_out_d;
      data_valid_out_q <= data_valid_out_d;
      sync_err_q       <= sync_err_d;
    end
  end

  assign patternReset = pattern_reset_q;
  assign LFSRSel      = lfsr_sel_q;
  assign advance      = advance_q;
  assign bypass       = bypass_q;
  assign dataOut      = data_out_q;
  assign dataValidOut = data_valid_out_q;
  assign syncErr      = sync_err_q;

endmodule

// File: tb/tb_rx_descramble_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_descramble_ctrl
// Self-checking bench: a block-position reference model predicts every
// registered output; each scenario task also checks the fixed values the
// scenario is expected to produce.
// ---------------------------------------------------------------------------
module tb_rx_descramble_ctrl;

  logic        clk;
  logic        reset;
  logic        turnOff;
  logic [5:0]  PIPEWIDTH;
  logic        dataValid;
  logic        blockStart;
  logic [1:0]  syncHeader;
  logic [31:0] rxData;
  logic        patternReset;
  logic [1:0]  LFSRSel;
  logic [3:0]  advance;
  logic [3:0]  bypass;
  logic [31:0] dataOut;
  logic        dataValidOut;
  logic        syncErr;

  int n_tests;
  int n_fail;

  // reference model state: block type (0 none,1 data,2 os,3 skp,4 eieos),
  // symbols consumed in the block (0..16), symbols per word
  int m_type;
  int m_pos;
  int m_n;

  logic [3:0]  e_adv;
  logic [3:0]  e_byp;
  logic        e_pr;
  logic        e_err;
  logic [1:0]  e_sel;
  logic        e_dvo;
  logic [31:0] e_data;

  rx_descramble_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .turnOff      (turnOff),
    .PIPEWIDTH    (PIPEWIDTH),
    .dataValid    (dataValid),
    .blockStart   (blockStart),
    .syncHeader   (syncHeader),
    .rxData       (rxData),
    .patternReset (patternReset),
    .LFSRSel      (LFSRSel),
    .advance      (advance),
    .bypass       (bypass),
    .dataOut      (dataOut),
    .dataValidOut (dataValidOut),
    .syncErr      (syncErr)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int lanes;
    if (reset) begin
      m_type = 0; m_pos = 0; m_n = 4;
      e_pr = 1'b1; e_adv = 4'h0; e_byp = 4'hF; e_err = 1'b0;
      e_data = 32'h0; e_dvo = 1'b0; e_sel = 2'd2;
      return;
    end
    e_data = rxData; e_dvo = dataValid;
    e_adv = 4'h0; e_byp = 4'hF; e_pr = 1'b0; e_err = 1'b0;
    if (turnOff) begin
      m_type = 0; m_pos = 0; e_pr = 1'b1;
    end else if (dataValid) begin
      if (blockStart) begin
        e_err = (m_pos != 0 && m_pos != 16) || !(syncHeader == 2'b10 || syncHeader == 2'b01);
        m_n = (PIPEWIDTH == 6'd8) ? 1 : (PIPEWIDTH == 6'd16) ? 2 : 4;
        m_pos = 0;
        if (syncHeader == 2'b10) m_type = 1;
        else if (syncHeader == 2'b01) m_type = (rxData[7:0] == 8'hAA) ? 3 : (rxData[7:0] == 8'h00) ? 4 : 2;
        else m_type = 0;
      end else if (m_pos == 16) begin
        m_type = 0; m_pos = 0;
      end
      if (m_type != 0) begin
        lanes = (1 << m_n) - 1;
        if (m_type == 1) begin e_adv = lanes[3:0]; e_byp = ~lanes[3:0]; end
        if (m_type == 2) e_adv = lanes[3:0];
        if (m_type == 4 && m_pos + m_n == 16) e_pr = 1'b1;
        m_pos = m_pos + m_n;
      end
    end
    e_sel = (m_n == 1) ? 2'd0 : (m_n == 2) ? 2'd1 : 2'd2;
  endtask

  // apply one word, predict, clock, settle past the edge
  task automatic cyc(input logic v, input logic bs, input logic [1:0] hdr, input logic [31:0] d);
    dataValid = v; blockStart = bs; syncHeader = hdr; rxData = d;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; turnOff = 1'b1; PIPEWIDTH = 6'd8;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 2'b10, $urandom);
      n_tests++;
      if ({patternReset, advance, bypass, syncErr, dataOut, dataValidOut, LFSRSel} !== {1'b1, 4'h0, 4'hF, 1'b0, 32'h0, 1'b0, 2'd2}) begin
        n_fail++;
        $display("FAIL reset_values: got pr=%b adv=%h byp=%h err=%b do=%h dvo=%b sel=%0d, expected pr=1 adv=0 byp=f err=0 do=0 dvo=0 sel=2",
                 patternReset, advance, bypass, syncErr, dataOut, dataValidOut, LFSRSel);
      end
    end
    reset = 1'b0; turnOff = 1'b0;
    cyc(1'b0, 1'b0, 2'b00, 32'h0);
    n_tests++;
    if (patternReset !== 1'b0 || {advance, bypass, syncErr} !== {e_adv, e_byp, e_err}) begin
      n_fail++;
      $display("FAIL reset_release: got pr=%b adv=%h byp=%h err=%b, expected pr=0 adv=%h byp=%h err=%b",
               patternReset, advance, bypass, syncErr, e_adv, e_byp, e_err);
    end
  endtask

  task automatic test_data_block();
    PIPEWIDTH = 6'd32;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, (i == 0), 2'b10, $urandom);
      n_tests++;
      if ({advance, bypass, patternReset, syncErr, LFSRSel, dataValidOut, dataOut} !== {e_adv, e_byp, e_pr, e_err, e_sel, e_dvo, e_data}) begin
        n_fail++;
        $display("FAIL data_block_model[%0d]: got adv=%h byp=%h pr=%b err=%b sel=%0d dvo=%b do=%h, expected adv=%h byp=%h pr=%b err=%b sel=%0d dvo=%b do=%h",
                 i, advance, bypass, patternReset, syncErr, LFSRSel, dataValidOut, dataOut, e_adv, e_byp, e_pr, e_err, e_sel, e_dvo, e_data);
      end
      n_tests++;
      if ({advance, bypass} !== ((i < 4) ? 8'hF0 : 8'h0F)) begin
        n_fail++;
        $display("FAIL data_block_lanes[%0d]: got adv=%h byp=%h", i, advance, bypass);
      end
    end
  endtask

  task automatic test_skp_block();
    PIPEWIDTH = 6'd32;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, (i == 0), 2'b01, (i == 0) ? {$urandom_range(0, 65535), 8'hAB, 8'hAA} : $urandom);
      n_tests++;
      if ({advance, bypass, patternReset, syncErr, LFSRSel, dataValidOut, dataOut} !== {e_adv, e_byp, e_pr, e_err, e_sel, e_dvo, e_data}) begin
        n_fail++;
        $display("FAIL skp_model[%0d]: got adv=%h byp=%h pr=%b err=%b, expected adv=%h byp=%h pr=%b err=%b",
                 i, advance, bypass, patternReset, syncErr, e_adv, e_byp, e_pr, e_err);
      end
      n_tests++;
      if ({advance, bypass, patternReset} !== {4'h0, 4'hF, 1'b0}) begin
        n_fail++;
        $display("FAIL skp_fixed[%0d]: got adv=%h byp=%h pr=%b, expected adv=0 byp=f pr=0", i, advance, bypass, patternReset);
      end
    end
  endtask

  task automatic test_eieos_block();
    PIPEWIDTH = 6'd8;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, (i == 0), 2'b01, (i == 0) ? {$urandom_range(0, 16777215), 8'h00} : $urandom);
      n_tests++;
      if ({advance, bypass, patternReset, syncErr, LFSRSel, dataValidOut, dataOut} !== {e_adv, e_byp, e_pr, e_err, e_sel, e_dvo, e_data}) begin
        n_fail++;
        $display("FAIL eieos_model[%0d]: got adv=%h byp=%h pr=%b sel=%0d, expected adv=%h byp=%h pr=%b sel=%0d",
                 i, advance, bypass, patternReset, LFSRSel, e_adv, e_byp, e_pr, e_sel);
      end
      n_tests++;
      if ({advance, bypass, patternReset, LFSRSel} !== {4'h0, 4'hF, (i == 15), 2'd0}) begin
        n_fail++;
        $display("FAIL eieos_fixed[%0d]: got adv=%h byp=%h pr=%b sel=%0d, expected pr=%b", i, advance, bypass, patternReset, LFSRSel, (i == 15));
      end
    end
  endtask

  task automatic test_misalign();
    PIPEWIDTH = 6'd16;
    // three words reach symbol 6, then an OS block starts early; 7 more words finish it
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, (i == 0 || i == 3), (i == 0) ? 2'b10 : 2'b01, (i == 3) ? {$urandom_range(0, 65535), 8'h5A, 8'h1C} : $urandom);
      n_tests++;
      if ({advance, bypass, patternReset, syncErr, LFSRSel, dataValidOut, dataOut} !== {e_adv, e_byp, e_pr, e_err, e_sel, e_dvo, e_data}) begin
        n_fail++;
        $display("FAIL misalign_model[%0d]: got adv=%h byp=%h err=%b, expected adv=%h byp=%h err=%b",
                 i, advance, bypass, syncErr, e_adv, e_byp, e_err);
      end
      n_tests++;
      if (syncErr !== (i == 3) || (i >= 3 && i <= 10 && {advance, bypass} !== 8'h3F)) begin
        n_fail++;
        $display("FAIL misalign_fixed[%0d]: got err=%b adv=%h byp=%h, expected err=%b adv=3 byp=f", i, syncErr, advance, bypass, (i == 3));
      end
    end
  endtask

  task automatic test_turnoff();
    PIPEWIDTH = 6'd32;
    for (int i = 0; i < 5; i++) begin
      turnOff = (i == 2);
      cyc(1'b1, (i == 0 || i == 4), 2'b10, $urandom);
      n_tests++;
      if ({advance, bypass, patternReset, syncErr, LFSRSel, dataValidOut, dataOut} !== {e_adv, e_byp, e_pr, e_err, e_sel, e_dvo, e_data}) begin
        n_fail++;
        $display("FAIL turnoff_model[%0d]: got adv=%h byp=%h pr=%b err=%b, expected adv=%h byp=%h pr=%b err=%b",
                 i, advance, bypass, patternReset, syncErr, e_adv, e_byp, e_pr, e_err);
      end
      n_tests++;
      if ((i == 2 && {patternReset, advance, bypass, syncErr} !== {1'b1, 4'h0, 4'hF, 1'b0}) ||
          (i == 3 && {patternReset, advance, bypass} !== {1'b0, 4'h0, 4'hF}) ||
          (i == 4 && advance !== 4'hF)) begin
        n_fail++;
        $display("FAIL turnoff_fixed[%0d]: got pr=%b adv=%h byp=%h err=%b", i, patternReset, advance, bypass, syncErr);
      end
    end
    turnOff = 1'b0;
    // finish the block started at i == 4
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 2'b00, $urandom);
  endtask

  task automatic test_bad_header();
    PIPEWIDTH = 6'd32;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, (i == 0 || i == 2), (i == 0) ? 2'b11 : 2'b00, $urandom);
      n_tests++;
      if ({advance, bypass, patternReset, syncErr, LFSRSel, dataValidOut, dataOut} !== {e_adv, e_byp, e_pr, e_err, e_sel, e_dvo, e_data}) begin
        n_fail++;
        $display("FAIL bad_header_model[%0d]: got adv=%h byp=%h err=%b, expected adv=%h byp=%h err=%b",
                 i, advance, bypass, syncErr, e_adv, e_byp, e_err);
      end
      n_tests++;
      if ({syncErr, advance, bypass} !== {(i == 0 || i == 2), 4'h0, 4'hF}) begin
        n_fail++;
        $display("FAIL bad_header_fixed[%0d]: got err=%b adv=%h byp=%h", i, syncErr, advance, bypass);
      end
    end
  endtask

  task automatic test_width_hold();
    // width changes mid-block must not alter lanes; invalid cycles hold position
    PIPEWIDTH = 6'd32;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) PIPEWIDTH = 6'd8;
      cyc((i != 2), (i == 0), 2'b10, $urandom);
      n_tests++;
      if ({advance, bypass, patternReset, syncErr, LFSRSel, dataValidOut, dataOut} !== {e_adv, e_byp, e_pr, e_err, e_sel, e_dvo, e_data}) begin
        n_fail++;
        $display("FAIL width_hold_model[%0d]: got adv=%h byp=%h sel=%0d dvo=%b, expected adv=%h byp=%h sel=%0d dvo=%b",
                 i, advance, bypass, LFSRSel, dataValidOut, e_adv, e_byp, e_sel, e_dvo);
      end
      n_tests++;
      if ({advance, LFSRSel} !== {((i == 2 || i == 5) ? 4'h0 : 4'hF), 2'd2}) begin
        n_fail++;
        $display("FAIL width_hold_fixed[%0d]: got adv=%h sel=%0d", i, advance, LFSRSel);
      end
    end
  endtask

  task automatic test_reset_priority();
    PIPEWIDTH = 6'd16;
    cyc(1'b1, 1'b1, 2'b01, 32'h1234_5611);
    reset = 1'b1; turnOff = 1'b1;
    cyc(1'b1, 1'b0, 2'b01, $urandom);
    n_tests++;
    if ({patternReset, advance, bypass, syncErr, dataOut, dataValidOut, LFSRSel} !== {1'b1, 4'h0, 4'hF, 1'b0, 32'h0, 1'b0, 2'd2}) begin
      n_fail++;
      $display("FAIL reset_priority: got pr=%b adv=%h byp=%h err=%b do=%h dvo=%b sel=%0d",
               patternReset, advance, bypass, syncErr, dataOut, dataValidOut, LFSRSel);
    end
    reset = 1'b0; turnOff = 1'b0;
    cyc(1'b1, 1'b1, 2'b10, $urandom);
    n_tests++;
    if ({syncErr, advance, bypass} !== {1'b0, 4'h3, 4'hC}) begin
      n_fail++;
      $display("FAIL reset_priority_restart: got err=%b adv=%h byp=%h, expected err=0 adv=3 byp=c", syncErr, advance, bypass);
    end
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 2'b00, $urandom);
  endtask

  task automatic test_random();
    logic [5:0] widths [4];
    logic [7:0] ids [4];
    int pos;
    int n;
    widths[0] = 6'd8; widths[1] = 6'd16; widths[2] = 6'd32; widths[3] = 6'd5;
    ids[0] = 8'hAA; ids[1] = 8'h00; ids[2] = 8'h2D; ids[3] = 8'h1E;
    pos = 0; n = 4;
    for (int i = 0; i < 600; i++) begin
      logic bs;
      logic v;
      logic [1:0] hdr;
      logic [31:0] d;
      v = ($urandom_range(0, 7) != 0);
      turnOff = ($urandom_range(0, 60) == 0);
      PIPEWIDTH = widths[$urandom_range(0, 3)];
      bs = (pos == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 40) == 0);
      hdr = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01);
      d = $urandom;
      d[7:0] = ids[$urandom_range(0, 3)];
      if (v && bs) n = (PIPEWIDTH == 6'd8) ? 1 : (PIPEWIDTH == 6'd16) ? 2 : 4;
      if (v) pos = (bs ? n : pos + n) % 16;
      cyc(v, bs, hdr, d);
      n_tests++;
      if ({advance, bypass, patternReset, syncErr, LFSRSel, dataValidOut, dataOut} !== {e_adv, e_byp, e_pr, e_err, e_sel, e_dvo, e_data}) begin
        n_fail++;
        $display("FAIL random[%0d]: got adv=%h byp=%h pr=%b err=%b sel=%0d dvo=%b do=%h, expected adv=%h byp=%h pr=%b err=%b sel=%0d dvo=%b do=%h",
                 i, advance, bypass, patternReset, syncErr, LFSRSel, dataValidOut, dataOut, e_adv, e_byp, e_pr, e_err, e_sel, e_dvo, e_data);
      end
    end
    turnOff = 1'b0;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; turnOff = 1'b0; PIPEWIDTH = 6'd32;
    dataValid = 1'b0; blockStart = 1'b0; syncHeader = 2'b00; rxData = 32'h0;
    n_tests = 0; n_fail = 0;
    m_type = 0; m_pos = 0; m_n = 4;
    test_reset();
    test_data_block();
    test_skp_block();
    test_eieos_block();
    test_misalign();
    test_turnoff();
    test_bad_header();
    test_width_hold();
    test_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
